// File: rtl/matrix_col_cal.sv
// Column-pass 16-point Walsh-Hadamard transform (natural order), four registered
// butterfly stages with a valid/ready pipeline and per-block last-beat framing.
module matrix_col_cal #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BLK_COLS   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tmp_col_vld,
   output logic                         tmp_col_rdy,
   input  logic [16*(DATA_WIDTH+4)-1:0] tmp_col_data,
   output logic                         dst_col_vld,
   input  logic                         dst_col_rdy,
   output logic [16*(DATA_WIDTH+8)-1:0] dst_col_data,
   output logic                         dst_col_last
);

   localparam int unsigned IW = DATA_WIDTH + 4;
   localparam int unsigned OW = DATA_WIDTH + 8;
   localparam int unsigned CW = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;

   logic [4:1]       r_v;
   logic             w_rdy1, w_rdy2, w_rdy3, w_rdy4;
   logic [4:1]       w_ld;
   logic [CW-1:0]    r_cnt;
   // Stage buses carried at output width, sign-extended, so every stage reads one format
   logic [16*OW-1:0] w_link [5];

   assign w_rdy4      = !r_v[4] || dst_col_rdy;
   assign w_rdy3      = !r_v[3] || w_rdy4;
   assign w_rdy2      = !r_v[2] || w_rdy3;
   assign w_rdy1      = !r_v[1] || w_rdy2;
   assign w_ld        = {w_rdy4, w_rdy3, w_rdy2, w_rdy1};
   assign tmp_col_rdy = w_rdy1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v <= '0;
      end else begin
         if (w_ld[1]) r_v[1] <= tmp_col_vld;
         if (w_ld[2]) r_v[2] <= r_v[1];
         if (w_ld[3]) r_v[3] <= r_v[2];
         if (w_ld[4]) r_v[4] <= r_v[3];
      end
   end

   for (genvar k = 0; k < 16; k++) begin : g_in
      assign w_link[0][k*OW +: OW] = OW'($signed(tmp_col_data[k*IW +: IW]));
   end

   for (genvar s = 1; s <= 4; s++) begin : g_stage
      localparam int unsigned WO = IW + s;
      localparam int unsigned H  = 1 << (s - 1);

      logic signed [WO-1:0] w_a [16];
      logic signed [WO-1:0] w_f [16];
      logic signed [WO-1:0] r_d [16];

      for (genvar k = 0; k < 16; k++) begin : g_elem
         assign w_a[k] = WO'($signed(w_link[s-1][k*OW +: OW]));
         assign w_link[s][k*OW +: OW] = OW'(r_d[k]);
         if ((k & H) == 0) begin : g_sum
            assign w_f[k] = w_a[k] + w_a[k+H];
         end else begin : g_dif
            assign w_f[k] = w_a[k-H] - w_a[k];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_d <= '{default: '0};
         end else if (w_ld[s]) begin
            r_d <= w_f;
         end
      end
   end

   assign dst_col_vld  = r_v[4];
   assign dst_col_data = w_link[4];
   assign dst_col_last = r_v[4] && (r_cnt == CW'(BLK_COLS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (dst_col_vld && dst_col_rdy) begin
         if (r_cnt == CW'(BLK_COLS - 1)) r_cnt <= '0;
         else                            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_matrix_col_cal.sv
// Self-checking bench for matrix_col_cal: Hadamard-sum reference model with an
// expected-output queue, checked every cycle, plus literal transform and framing checks.
module tb_matrix_col_cal;

   localparam int DW  = 8;
   localparam int IW  = DW + 4;
   localparam int OW  = DW + 8;
   localparam int BLK = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              tmp_col_vld;
   logic              tmp_col_rdy;
   logic [16*IW-1:0]  tmp_col_data;
   logic              dst_col_vld;
   logic              dst_col_rdy;
   logic [16*OW-1:0]  dst_col_data;
   logic              dst_col_last;

   int               nchk = 0;
   int               nerr = 0;
   logic [16*OW-1:0] expq [$];
   int               mcnt = 0;
   int               out_beats = 0;
   int               last_hits = 0;

   always #5 clk = ~clk;

   matrix_col_cal #(.DATA_WIDTH(DW), .BLK_COLS(BLK)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .tmp_col_vld  (tmp_col_vld),
      .tmp_col_rdy  (tmp_col_rdy),
      .tmp_col_data (tmp_col_data),
      .dst_col_vld  (dst_col_vld),
      .dst_col_rdy  (dst_col_rdy),
      .dst_col_data (dst_col_data),
      .dst_col_last (dst_col_last)
   );

   // coeff k = sum_n (-1)^popcount(k&n) * x[n]
   function automatic logic [16*OW-1:0] wht(input logic [16*IW-1:0] v);
      logic [16*OW-1:0] r;
      logic signed [IW-1:0] e;
      int acc;
      int x;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         acc = 0;
         for (int n = 0; n < 16; n++) begin
            e = v[n*IW +: IW];
            x = e;
            if (($countones(k & n) % 2) == 1) acc -= x;
            else                               acc += x;
         end
         r[k*OW +: OW] = acc[OW-1:0];
      end
      return r;
   endfunction

   function automatic logic [16*IW-1:0] rand_vec();
      logic [16*IW-1:0] v;
      for (int k = 0; k < 16; k++) begin
         case ($urandom_range(7, 0))
            0:       v[k*IW +: IW] = 12'h7FF;
            1:       v[k*IW +: IW] = 12'h800;
            default: v[k*IW +: IW] = IW'($urandom);
         endcase
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [16*OW-1:0] act, input logic [16*OW-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic monitor();
      if (rst) begin
         expq.delete();
         mcnt = 0;
      end else begin
         if (dst_col_vld) begin
            if (expq.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_output actual=%h required=none", dst_col_data);
            end else begin
               check("data", dst_col_data, expq[0]);
               check("last", dst_col_last, (mcnt == BLK - 1));
               if (dst_col_rdy) begin
                  void'(expq.pop_front());
                  out_beats++;
                  if (dst_col_last) last_hits++;
                  mcnt = (mcnt == BLK - 1) ? 0 : mcnt + 1;
               end
            end
         end else begin
            check("last_idle", dst_col_last, 1'b0);
         end
         if (tmp_col_vld && tmp_col_rdy) expq.push_back(wht(tmp_col_data));
      end
   endtask

   task automatic step(output bit fired);
      @(negedge clk);
      monitor();
      fired = tmp_col_vld && tmp_col_rdy && !rst;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      bit f;
      rst = 1'b1;
      step(f);
      rst = 1'b0;
   endtask

   task automatic drain();
      bit f;
      int n = 0;
      while ((expq.size() != 0 || dst_col_vld) && n < 300) begin
         step(f);
         n++;
      end
      check("drain_empty", expq.size(), 0);
   endtask

   task automatic send_one(input string name, input logic [16*IW-1:0] v, input logic [16*OW-1:0] exp);
      bit f;
      int n = 0;
      tmp_col_vld  = 1'b1;
      tmp_col_data = v;
      f = 1'b0;
      while (!f && n < 50) begin
         step(f);
         n++;
      end
      tmp_col_vld = 1'b0;
      n = 0;
      while (!dst_col_vld && n < 50) begin
         step(f);
         n++;
      end
      check(name, dst_col_data, exp);
      drain();
   endtask

   task automatic stream(input int n, input bit gaps);
      bit f;
      int sent = 0;
      int off_left = 0;
      int cyc = 0;
      int on_left;
      int rl;
      on_left      = gaps ? int'($urandom_range(10, 1)) : n;
      rl           = int'($urandom_range(10, 1));
      dst_col_rdy  = 1'b1;
      tmp_col_vld  = 1'b0;
      while (sent < n && cyc < 4000) begin
         if (!tmp_col_vld) begin
            if (off_left > 0) off_left--;
            else begin
               tmp_col_vld  = 1'b1;
               tmp_col_data = rand_vec();
            end
         end
         if (gaps) begin
            if (rl == 0) begin
               dst_col_rdy = !dst_col_rdy;
               rl = dst_col_rdy ? int'($urandom_range(10, 1)) : int'($urandom_range(5, 1));
            end else rl--;
         end
         step(f);
         cyc++;
         if (f) begin
            sent++;
            tmp_col_vld = 1'b0;
            if (gaps) begin
               on_left--;
               if (on_left == 0) begin
                  off_left = int'($urandom_range(11, 3));
                  on_left  = int'($urandom_range(10, 1));
               end
            end
         end
      end
      check("stream_sent", sent, n);
      tmp_col_vld = 1'b0;
      dst_col_rdy = 1'b1;
      drain();
   endtask

   initial begin
      logic [16*IW-1:0] imp, ones_in, neg_in, ext_in;
      logic [16*OW-1:0] all1, dc1, dcneg, ext_out;
      logic [16*IW-1:0] bpv [6];
      bit f;
      int lat, idx, base, lb;

      for (int k = 0; k < 16; k++) begin
         imp[k*IW +: IW]     = (k == 0) ? 12'd1 : 12'd0;
         ones_in[k*IW +: IW] = 12'd1;
         neg_in[k*IW +: IW]  = 12'h800;
         ext_in[k*IW +: IW]  = (k % 2 == 0) ? 12'h7FF : 12'h800;
         all1[k*OW +: OW]    = 16'd1;
         dc1[k*OW +: OW]     = (k == 0) ? 16'd16 : 16'd0;
         dcneg[k*OW +: OW]   = (k == 0) ? 16'h8000 : 16'd0;
         ext_out[k*OW +: OW] = (k == 0) ? 16'hFFF8 : ((k == 1) ? 16'h7FF8 : 16'd0);
      end

      rst          = 1'b1;
      tmp_col_vld  = 1'b0;
      tmp_col_data = '0;
      dst_col_rdy  = 1'b1;
      repeat (3) step(f);
      rst = 1'b0;
      check("reset_vld", dst_col_vld, 1'b0);
      check("reset_last", dst_col_last, 1'b0);
      check("reset_data", dst_col_data, '0);
      check("reset_rdy", tmp_col_rdy, 1'b1);
      check("reset_cnt", u_dut.r_cnt, 0);

      check("model_impulse", wht(imp), all1);
      check("model_dc", wht(ones_in), dc1);
      check("model_neg", wht(neg_in), dcneg);
      check("model_ext", wht(ext_in), ext_out);

      tmp_col_vld  = 1'b1;
      tmp_col_data = imp;
      step(f);
      check("impulse_accept", f, 1'b1);
      tmp_col_vld = 1'b0;
      lat = 1;
      while (!dst_col_vld && lat < 20) begin
         step(f);
         lat++;
      end
      check("latency", lat, 4);
      check("impulse", dst_col_data, all1);
      drain();

      send_one("dc_ones", ones_in, dc1);
      send_one("dc_neg", neg_in, dcneg);
      send_one("extremes", ext_in, ext_out);

      stream(30, 1'b1);

      base = out_beats;
      for (int i = 0; i < 6; i++) bpv[i] = rand_vec();
      dst_col_rdy  = 1'b0;
      idx          = 0;
      tmp_col_vld  = 1'b1;
      tmp_col_data = bpv[0];
      for (int c = 0; c < 10; c++) begin
         step(f);
         if (f) begin
            idx++;
            tmp_col_data = bpv[idx];
         end
      end
      check("bp_accepted", idx, 4);
      check("bp_rdy_low", tmp_col_rdy, 1'b0);
      dst_col_rdy = 1'b1;
      lat = 0;
      while (idx < 6 && lat < 50) begin
         step(f);
         lat++;
         if (f) begin
            idx++;
            if (idx < 6) tmp_col_data = bpv[idx];
            else         tmp_col_vld  = 1'b0;
         end
      end
      tmp_col_vld = 1'b0;
      drain();
      check("bp_emitted", out_beats - base, 6);

      pulse_reset();
      base = out_beats;
      lb   = last_hits;
      stream(40, 1'b1);
      check("frame_beats", out_beats - base, 40);
      check("frame_lasts", last_hits - lb, 2);
      check("frame_cnt", u_dut.r_cnt, 8);

      dst_col_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tmp_col_vld  = 1'b1;
         tmp_col_data = rand_vec();
         step(f);
      end
      tmp_col_vld = 1'b0;
      check("midrst_inflight", u_dut.r_v, 4'b0111);
      pulse_reset();
      check("midrst_vld", dst_col_vld, 1'b0);
      check("midrst_cnt", u_dut.r_cnt, 0);
      check("midrst_rdy", tmp_col_rdy, 1'b1);
      dst_col_rdy = 1'b1;
      base = out_beats;
      lb   = last_hits;
      stream(16, 1'b0);
      check("fresh_beats", out_beats - base, 16);
      check("fresh_lasts", last_hits - lb, 1);

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
